kyo_hit_seq: RTL and testbench
==============================

KYO_HIT_SEQ -- requirements
Module: kyo_hit_seq

Interface
REQ-001 Parameter FRAME_HOLD, default 6, number of video frames each animation frame is held (legal range 1..15).
REQ-002 The module SHALL have one clock and a synchronous, active-high reset: vga_clk and reset.
REQ-003 vga_clk  input  1  pixel clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hit  input  1  single-cycle pulse; start or restart the hit animation.
REQ-006 frame_start  input  1  single-cycle pulse at the first pixel of each video frame.
REQ-007 facing_left  input  1  1 = mirror the sprite horizontally.
REQ-008 pos_x, pos_y  input  10 each  top-left screen coordinate of the sprite.
REQ-009 draw_x, draw_y  input  10 each  current beam coordinate.
REQ-010 rom_address  output  13  sprite ROM address for the downstream sprite renderer.
REQ-011 sprite_on  output  1  rom_address addresses a valid in-box pixel.
REQ-012 pixel_valid  output  1  sprite_on delayed 1 cycle, aligned with the renderer's RGB output.
REQ-013 busy  output  1  high in PLAY and DONE.
REQ-014 done  output  1  single-cycle pulse when the animation completes.

Function
REQ-015 Sprite geometry: 32 wide x 64 high, 4 frames; frame n occupies addresses n*2048 .. n*2048+2047, row-major.
REQ-016 The FSM SHALL have three states: IDLE, PLAY, DONE.
REQ-017 IDLE -> PLAY on hit. frame_idx=0, hold_cnt=0. A coincident frame_start is ignored.
REQ-018 In PLAY, each frame_start increments hold_cnt. When hold_cnt reaches FRAME_HOLD-1 and frame_start arrives, hold_cnt returns to 0 and frame_idx increments.
REQ-019 PLAY -> DONE when frame_start arrives with frame_idx=3 and hold_cnt=FRAME_HOLD-1. DONE lasts exactly 1 cycle with done=1, then goes to IDLE.
REQ-020 hit in PLAY or DONE SHALL restart the animation: frame_idx=0, hold_cnt=0, state PLAY, no done pulse. Hit takes priority over a coincident frame_start.
REQ-021 In-box test: pos_x <= draw_x < pos_x+32 and pos_y <= draw_y < pos_y+64, with sums computed at 11 bits so boxes that extend past 1023 do not wrap.
REQ-022 rel_x = draw_x-pos_x (5 bits), rel_y = draw_y-pos_y (6 bits). col = facing_left ? 31-rel_x : rel_x.
REQ-023 Address = {frame_idx, rel_y, col}, 13 bits, with no overflow possible.
REQ-024 rom_address and sprite_on SHALL be registered with latency 1 cycle from draw_x/draw_y.
REQ-025 sprite_on SHALL be 1 only when in-box and the state is PLAY or DONE. Otherwise sprite_on=0 and rom_address=0.
REQ-026 pixel_valid SHALL be sprite_on registered once more, giving 2-cycle latency from the coordinates.
REQ-027 frame_idx changes take effect on the address for the pixel of the cycle after frame_start.

Reset
REQ-028 On reset: state=IDLE, frame_idx=0, hold_cnt=0, rom_address=0, sprite_on=0, pixel_valid=0, busy=0, done=0.
REQ-029 Reset mid-PLAY SHALL abort without a done pulse. A hit asserted in the reset cycle is ignored.

Structure
REQ-030 SPRITE_W=32, SPRITE_H=64, NUM_FRAMES=4, FRAME_WORDS=2048 and the FSM state enum SHALL live in shared package kof_sprite_pkg.
REQ-031 The box-test/address arithmetic SHALL be one combinational sub-module, sprite_addr_calc, reusable by other character sequencers. The FSM and counters stay in kyo_hit_seq.

Verification
REQ-032 Reset, then hit with FRAME_HOLD=2, then 8 frame_start pulses -> frame_idx follows 0,0,1,1,2,2,3,3. On the 8th pulse done=1 for 1 cycle, then busy=0.
REQ-033 PLAY at frame 2, pos=(100,50), draw=(103,52), facing_left=0 -> next cycle rom_address=4096+2*32+3=4163 and sprite_on=1. The following cycle pixel_valid=1.
REQ-034 Same coordinates with facing_left=1 -> rom_address=4096+64+28=4188.
REQ-035 pos_x=1000, draw_x=1020 -> in-box, sprite_on=1. draw_x=5 -> sprite_on=0 and rom_address=0 (no wrap).
REQ-036 hit at frame 3 coincident with frame_start -> frame_idx=0, hold_cnt=0, no done pulse.
REQ-037 reset asserted during PLAY frame 1 -> all outputs at reset values the next cycle, no done pulse, IDLE ignores frame_start.

Source files
------------

// File: rtl/kof_sprite_pkg.sv
// Shared sprite geometry and sequencer state type for the KOF character sequencers.
package kof_sprite_pkg;

    localparam int SPRITE_W    = 32;
    localparam int SPRITE_H    = 64;
    localparam int NUM_FRAMES  = 4;
    localparam int FRAME_WORDS = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sprite_addr_calc.sv
// Combinational sprite box test and ROM address generation, shared by character sequencers.
module sprite_addr_calc
    import kof_sprite_pkg::*;
(
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        facing_left,
    input  logic [1:0]  frame_idx,
    output logic        in_box,
    output logic [12:0] addr
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [4:0]  rel_x;
    logic [5:0]  rel_y;
    logic [4:0]  col;

    // Box ends are 11 bits wide so sprites hanging past 1023 never wrap onto the left edge.
    assign x_end = {1'b0, pos_x} + 11'(SPRITE_W);
    assign y_end = {1'b0, pos_y} + 11'(SPRITE_H);

    assign in_box = (draw_x >= pos_x) && ({1'b0, draw_x} < x_end) &&
                    (draw_y >= pos_y) && ({1'b0, draw_y} < y_end);

    // Low bits of the difference equal the difference of the low bits; only in-box values matter.
    assign rel_x = draw_x[4:0] - pos_x[4:0];
    assign rel_y = draw_y[5:0] - pos_y[5:0];
    assign col   = facing_left ? (5'd31 - rel_x) : rel_x;

    assign addr  = {frame_idx, rel_y, col};

endmodule

// File: rtl/kyo_hit_seq.sv
// Kyo hit-reaction animation sequencer: frame pacing FSM plus registered sprite ROM addressing.
module kyo_hit_seq
    import kof_sprite_pkg::*;
#(
    parameter int FRAME_HOLD = 6
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        hit,
    input  logic        frame_start,
    input  logic        facing_left,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [12:0] rom_address,
    output logic        sprite_on,
    output logic        pixel_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] HOLD_LAST = 4'(FRAME_HOLD - 1);

    seq_state_t  state;
    logic [1:0]  frame_idx;
    logic [3:0]  hold_cnt;
    logic        in_box;
    logic [12:0] calc_addr;
    logic        show;

    sprite_addr_calc u_addr (
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .facing_left (facing_left),
        .frame_idx   (frame_idx),
        .in_box      (in_box),
        .addr        (calc_addr)
    );

    assign show = in_box && (state != IDLE);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= IDLE;
            frame_idx   <= 2'd0;
            hold_cnt    <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_address <= 13'd0;
            sprite_on   <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            // A hit restarts from any state and wins over a coincident frame_start.
            if (hit) begin
                state     <= PLAY;
                frame_idx <= 2'd0;
                hold_cnt  <= 4'd0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    PLAY: begin
                        busy <= 1'b1;
                        if (frame_start) begin
                            if (hold_cnt == HOLD_LAST) begin
                                hold_cnt <= 4'd0;
                                if (frame_idx == 2'(NUM_FRAMES - 1)) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    frame_idx <= frame_idx + 2'd1;
                                end
                            end else begin
                                hold_cnt <= hold_cnt + 4'd1;
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        frame_idx <= 2'd0;
                        hold_cnt  <= 4'd0;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            // Address stage, then one more stage to line up with the renderer's RGB.
            sprite_on   <= show;
            rom_address <= show ? calc_addr : 13'd0;
            pixel_valid <= sprite_on;
        end
    end

endmodule

// File: tb/tb_kyo_hit_seq.sv
// Self-checking bench for kyo_hit_seq: vector table, corner sequences and random traffic vs a model.
module tb_kyo_hit_seq;

    localparam int FH = 2;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        hit = 1'b0;
    logic        frame_start = 1'b0;
    logic        facing_left = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [9:0]  draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic [12:0] rom_address;
    logic        sprite_on;
    logic        pixel_valid;
    logic        busy;
    logic        done;

    kyo_hit_seq #(.FRAME_HOLD(FH)) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .hit         (hit),
        .frame_start (frame_start),
        .facing_left (facing_left),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .rom_address (rom_address),
        .sprite_on   (sprite_on),
        .pixel_valid (pixel_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;

    // Model: animation is "active" from hit until the done cycle ends; progress is the count
    // of frame_starts seen since the hit, and the displayed frame is that count / FH.
    bit m_active = 0;
    bit m_done   = 0;
    int m_cnt    = 0;
    bit m_so     = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit h, input bit fs, input bit fl,
                        input int px, input int py, input int dx, input int dy);
        bit inb;
        bit eso;
        bit epv;
        int frm;
        int col;
        int ea;
        reset = r; hit = h; frame_start = fs; facing_left = fl;
        pos_x = 10'(px); pos_y = 10'(py); draw_x = 10'(dx); draw_y = 10'(dy);

        inb = (dx >= px) && (dx < px + 32) && (dy >= py) && (dy < py + 64);
        frm = m_cnt / FH;
        if (frm > 3) frm = 3;
        eso = !r && m_active && inb;
        col = fl ? 31 - (dx - px) : (dx - px);
        ea  = eso ? frm * 2048 + (dy - py) * 32 + col : 0;
        epv = r ? 1'b0 : m_so;
        m_so = eso;

        if (r) begin
            m_active = 0; m_done = 0; m_cnt = 0;
        end else if (h) begin
            m_active = 1; m_done = 0; m_cnt = 0;
        end else if (m_done) begin
            m_active = 0; m_done = 0; m_cnt = 0;
        end else if (m_active && fs) begin
            m_cnt++;
            if (m_cnt == 4 * FH) m_done = 1;
        end

        @(posedge vga_clk);
        #1;
        chk("rom_address", int'(rom_address), ea);
        chk("sprite_on",   int'(sprite_on),   int'(eso));
        chk("pixel_valid", int'(pixel_valid), int'(epv));
        chk("busy",        int'(busy),        int'(m_active));
        chk("done",        int'(done),        int'(m_done));
    endtask

    typedef struct {
        bit fl;
        int px, py, dx, dy;
        int exp_addr;
        bit exp_on;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 100,  50,  103,  52, 4163, 1};
        vecs[1] = '{1, 100,  50,  103,  52, 4188, 1};
        vecs[2] = '{0, 1000, 50,  1020, 52, 4180, 1};
        vecs[3] = '{0, 1000, 50,  5,    52, 0,    0};
        vecs[4] = '{0, 100,  50,  99,   52, 0,    0};
        vecs[5] = '{0, 100,  50,  131,  113, 6143, 1};
        vecs[6] = '{0, 100,  50,  132,  52, 0,    0};
        vecs[7] = '{0, 100,  50,  100,  114, 0,   0};

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sprite_on", int'(sprite_on), 0);
        step(0, 0, 1, 0, 0, 0, 3, 2);
        chk("idle_no_sprite", int'(sprite_on), 0);

        // Full animation with FRAME_HOLD=2: frame sequence 0,0,1,1,2,2,3,3 then done
        step(0, 1, 1, 0, 0, 0, 3, 2);
        step(0, 0, 0, 0, 0, 0, 3, 2);
        chk("seq_frame0", int'(rom_address), 67);
        for (int p = 0; p < 8; p++) begin
            step(0, 0, 1, 0, 0, 0, 3, 2);
            if (p == 7) chk("seq_done_pulse", int'(done), 1);
            else        chk("seq_no_done", int'(done), 0);
            step(0, 0, 0, 0, 0, 0, 3, 2);
            if (p < 7) chk("seq_frame_addr", int'(rom_address), ((p + 1) / 2) * 2048 + 67);
            else       chk("seq_busy_low", int'(busy), 0);
        end

        // Address table at frame 2
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 4; p++) step(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, vecs[i].fl, vecs[i].px, vecs[i].py, vecs[i].dx, vecs[i].dy);
            chk("tbl_addr", int'(rom_address), vecs[i].exp_addr);
            chk("tbl_on", int'(sprite_on), int'(vecs[i].exp_on));
        end
        step(0, 0, 0, 0, 0, 0, 500, 500);
        chk("tbl_pv_follows", int'(pixel_valid), int'(vecs[7].exp_on));

        // Restart at frame 3 with coincident frame_start: no done, back to frame 0
        step(0, 1, 0, 0, 0, 0, 3, 2);
        for (int p = 0; p < 6; p++) step(0, 0, 1, 0, 0, 0, 3, 2);
        step(0, 1, 1, 0, 0, 0, 3, 2);
        chk("restart_no_done", int'(done), 0);
        chk("restart_old_frame", int'(rom_address), 3 * 2048 + 67);
        step(0, 0, 0, 0, 0, 0, 3, 2);
        chk("restart_frame0", int'(rom_address), 67);
        chk("restart_busy", int'(busy), 1);

        // Reset during frame 1 aborts silently; IDLE then ignores frame_start
        step(0, 0, 1, 0, 0, 0, 3, 2);
        step(0, 0, 1, 0, 0, 0, 3, 2);
        step(1, 1, 1, 0, 0, 0, 3, 2);
        chk("abort_busy", int'(busy), 0);
        chk("abort_addr", int'(rom_address), 0);
        for (int p = 0; p < 4; p++) begin
            step(0, 0, 1, 0, 0, 0, 3, 2);
            chk("abort_no_done", int'(done), 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            int px, py, dx, dy;
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
            dx = (px + int'($urandom_range(0, 40)) - 4) & 1023;
            dy = (py + int'($urandom_range(0, 72)) - 4) & 1023;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), px, py, dx, dy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
